// File: rtl/key_debounce_pkg.sv
// Shared types and 50 MHz default timing constants for the pushbutton debouncer.
package key_debounce_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } kd_state_t;

    localparam int DEF_DEBOUNCE_CYCLES = 1000000;   // 20 ms
    localparam int DEF_REPEAT_DELAY    = 25000000;  // 500 ms
    localparam int DEF_REPEAT_PERIOD   = 5000000;   // 100 ms

    // The encoding puts both "down" states in the upper half, so this reduces to one state flop.
    function automatic logic is_down(kd_state_t s);
        return (s == HELD) || (s == RELEASE_WAIT);
    endfunction

endpackage

// File: rtl/key_debounce_chan.sv
// One key channel: 2-flop synchroniser, debounce FSM and registered press/release pulses.
// Optional auto-repeat of press pulses while held, enabled by KEY_AUTOREPEAT_EN.
module key_debounce_chan
    import key_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      key,
    output kd_state_t state,
    output logic      press_pulse,
    output logic      release_pulse
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("key_debounce_chan: DEBOUNCE_CYCLES must be 2 or more");
    end
    if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
        $error("key_debounce_chan: REPEAT_DELAY and REPEAT_PERIOD must be 1 or more");
    end

    // Flops hold the raw active-low level, so reset to 1 means released.
    logic [1:0]    sync_ff;
    logic          pressed;
    kd_state_t     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          press_d, release_d, repeat_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_ff <= 2'b11;
        else        sync_ff <= {sync_ff[0], key};
    end

    assign pressed = ~sync_ff[1];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (pressed) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!pressed) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = HELD;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            HELD: begin
                if (!pressed) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (pressed) begin
                    state_d = HELD;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = IDLE;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef KEY_AUTOREPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX) + 1;
    localparam logic [RW-1:0] REP_FIRST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] REP_WRAP  = RW'(REPEAT_DELAY + REPEAT_PERIOD - 1);
    localparam logic [RW-1:0] REP_BASE  = RW'(REPEAT_DELAY);

    logic [RW-1:0] rcnt_q, rcnt_d;

    // After the first repeat the counter folds back to REPEAT_DELAY, so it never wraps.
    always_comb begin
        rcnt_d   = '0;
        repeat_d = 1'b0;
        if (state_q == HELD && pressed) begin
            if (rcnt_q == REP_WRAP) begin
                rcnt_d   = REP_BASE;
                repeat_d = 1'b1;
            end else begin
                rcnt_d   = rcnt_q + RW'(1);
                repeat_d = (rcnt_q == REP_FIRST);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rcnt_q <= '0;
        else        rcnt_q <= rcnt_d;
    end
`else
    assign repeat_d = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            press_pulse   <= press_d | repeat_d;
            release_pulse <= release_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/key_debounce.sv
// DE2 pushbutton conditioner: NUM_KEYS independent debounced channels on CLOCK_50.
// Define KEY_AUTOREPEAT_EN to add auto-repeat press pulses while a key is held.
module key_debounce
    import key_debounce_pkg::*;
#(
    parameter int NUM_KEYS        = 4,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic                CLOCK_50,
    input  logic                RESET_N,
    input  logic [NUM_KEYS-1:0] KEY,
    output logic [NUM_KEYS-1:0] key_down,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release
);

    kd_state_t chan_state [NUM_KEYS];

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_chan
        key_debounce_chan #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_chan (
            .clk           (CLOCK_50),
            .rst_n         (RESET_N),
            .key           (KEY[i]),
            .state         (chan_state[i]),
            .press_pulse   (key_press[i]),
            .release_pulse (key_release[i])
        );

        assign key_down[i] = is_down(chan_state[i]);
    end

endmodule

// File: doc/key_debounce.md
Name: key_debounce

Overview:
- Upstream conditioning stage for the DE2 pushbuttons (KEY[3:0], active-low, mechanically bouncy). Feeds the display counter stage.
- Synchronises each raw key to CLOCK_50 and debounces it.
- Outputs per key: a clean pressed level, a single-cycle press pulse and a single-cycle release pulse.
- Downstream logic counts on key_press under CLOCK_50 instead of clocking on a raw key edge.

Parameters:
- NUM_KEYS, 4: number of independent key channels.
- DEBOUNCE_CYCLES, 1000000: cycles a new level must hold before it is accepted (20 ms at 50 MHz); legal range is 2 or more.
- REPEAT_DELAY, 25000000: cycles in the held state before the first auto-repeat pulse. Used only with the optional feature.
- REPEAT_PERIOD, 5000000: cycles between subsequent auto-repeat pulses. Used only with the optional feature.

Ports:
- CLOCK_50  in  1  sole clock, 50 MHz, all logic on the rising edge.
- RESET_N  in  1  reset, asynchronous, active-low.
- KEY  in  NUM_KEYS  raw pushbuttons, 0 = pressed, asynchronous to CLOCK_50.
- key_down  out  NUM_KEYS  debounced level, 1 = pressed.
- key_press  out  NUM_KEYS  1-cycle pulse when a press is accepted.
- key_release  out  NUM_KEYS  1-cycle pulse when a release is accepted.

Behaviour:
- Reset (RESET_N=0, asynchronous):
  - All outputs are 0.
  - Synchroniser flops are 1 (released).
  - FSM is IDLE and all counters are 0.
  - Effect is immediate and holds regardless of KEY.
- Each channel is independent. Simultaneous events on several keys give pulses in the same cycle.
- Synchroniser: 2 flops on the inverted KEY; call its output sync, 1 = pressed.
- Per-channel FSM, 2-bit state:
  - IDLE: sync=1 -> PRESS_WAIT, cnt<=0.
  - PRESS_WAIT:
    - sync=0 -> IDLE. This is a bounce; no pulse.
    - Otherwise, if cnt==DEBOUNCE_CYCLES-1 -> HELD.
    - Otherwise cnt<=cnt+1.
  - HELD: sync=0 -> RELEASE_WAIT, cnt<=0.
  - RELEASE_WAIT:
    - sync=1 -> HELD. This is a bounce; no pulse.
    - Otherwise, if cnt==DEBOUNCE_CYCLES-1 -> IDLE.
    - Otherwise cnt<=cnt+1.
- Outputs, all registered, no combinational path from KEY:
  - key_press is 1 for exactly the first cycle in HELD when entered from PRESS_WAIT.
  - key_release is 1 for exactly the first cycle in IDLE when entered from RELEASE_WAIT.
  - key_down is 1 in HELD and RELEASE_WAIT. It changes in the same cycle as the corresponding pulse.
- Latency: the pulse appears after the (DEBOUNCE_CYCLES+2)th rising edge counted from the edge that first samples the new KEY level. This assumes the level is stable throughout.
- Bounce restart: any opposite sample in a WAIT state restarts qualification from zero on the next entry.
- Counter width is $clog2(max of the counted parameters)+1; counters never wrap.
- Reset deassert with a key already low: the key is treated as a fresh press and needs the full latency.

Optional Feature:
- Macro: KEY_AUTOREPEAT_EN.
- Defined:
  - Each channel has a repeat counter, cleared on entry to HELD and counting every cycle in HELD.
  - An extra key_press pulse is issued when the counter reaches REPEAT_DELAY.
  - Further pulses follow every REPEAT_PERIOD cycles while the channel stays in HELD.
  - The counter clears on leaving HELD, including a bounce into RELEASE_WAIT. No repeats are issued in RELEASE_WAIT.
  - key_release is unaffected.
- Undefined: exactly one key_press per accepted press, and no repeat counters are synthesised.

Decomposition:
- Package key_debounce_pkg:
  - kd_state_t enum (IDLE, PRESS_WAIT, HELD, RELEASE_WAIT).
  - Default constants for DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD at 50 MHz.
- Sub-module key_debounce_chan: one synchroniser + FSM + counters per key. Instantiated NUM_KEYS times in a generate loop.

Test Plan:
Bench parameters: DEBOUNCE_CYCLES=8, REPEAT_DELAY=20, REPEAT_PERIOD=6. Edge 0 is the first edge sampling the new KEY level.
1. Reset: RESET_N=0 with KEY=4'b0000 -> all outputs 0. Release reset with all keys still low -> key_press=4'b1111 after edge 10, key_down=4'b1111 from the same cycle.
2. Clean KEY[3] press held 40 cycles, then released -> exactly one key_press[3] pulse, after edge 10. key_release[3] pulse after edge 10 of the release, with key_down[3] falling in the same cycle. No other bits toggle.
3. Bounce on KEY[0]: low 5 cycles, high 2, low 5, then high -> no pulses and key_down[0]=0 throughout. A following low of 12 cycles -> one key_press[0].
4. KEY[1] and KEY[2] pressed on the same edge -> key_press=4'b0110 in a single cycle.
5. RESET_N pulsed low at edge 5 of a PRESS_WAIT with KEY held low -> outputs 0 immediately. After deassert, key_press only after a full 10 edges, never earlier.
6. KEY_AUTOREPEAT_EN defined, KEY[2] low for edges 0-59 -> key_press[2] pulses after edges 10, 30, 36, 42, 48, 54 and 60. Then no pulses; key_release[2] follows the debounce rule. Macro undefined -> only the edge-10 pulse.
